// File: rtl/id_stage_pkg.sv
// Shared decode-stage definitions: reset constants, instruction field ranges
// and immediate-extension codes used by id_stage and its register file.
package id_stage_pkg;

  localparam logic [31:0] PC_INIT_DEF   = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  localparam int unsigned RS_HI  = 25;
  localparam int unsigned RS_LO  = 21;
  localparam int unsigned RT_HI  = 20;
  localparam int unsigned RT_LO  = 16;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;

  typedef enum logic [1:0] {
    EXT_ZERO     = 2'b00,
    EXT_SIGN     = 2'b01,
    EXT_LUI      = 2'b10,
    EXT_ZERO_ALT = 2'b11
  } ext_op_e;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input ext_op_e op);
    logic [31:0] res;
    case (op)
      EXT_SIGN: res = {{16{imm[15]}}, imm};
      EXT_LUI:  res = {imm, 16'h0000};
      default:  res = {16'h0000, imm};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/id_stage_grf.sv
// 32x32 general register file: two combinational read ports with W->D bypass,
// one write port, async reset; $0 is never written.
module id_stage_grf (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        wr_en;

  assign wr_en = we && (waddr != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  // Bypass is suppressed during reset so operands read zero while it is held.
  always_comb begin
    rdata_a = regs_q[raddr_a];
    rdata_b = regs_q[raddr_b];
    if (wr_en && !rst && (waddr == raddr_a)) rdata_a = wdata;
    if (wr_en && !rst && (waddr == raddr_b)) rdata_b = wdata;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && wr_en) $display("@%h: $%d <= %h", pc, waddr, wdata);
  end
`endif

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register (stall > flush > load), register file with
// bypass, immediate extender and branch/jump feedback to the IFU.
module id_stage
  import id_stage_pkg::*;
#(
  parameter logic [31:0] PC_INIT   = PC_INIT_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] instr_f,
  input  logic [31:0] pc_and_4_f,
  input  logic [1:0]  ext_op,
  input  logic        we_w,
  input  logic [4:0]  waddr_w,
  input  logic [31:0] wdata_w,
  input  logic [31:0] pc_w,
  output logic [31:0] instr_d,
  output logic [31:0] pc_and_4_d,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] imm_ext,
  output logic        ifzero,
  output logic [31:0] ra_addr
);

  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pc_and_4_d_q, pc_and_4_d_d;

  always_comb begin
    instr_d_d    = instr_d_q;
    pc_and_4_d_d = pc_and_4_d_q;
    if (!stall) begin
      if (flush) begin
        instr_d_d = NOP_INSTR;
      end else begin
        instr_d_d    = instr_f;
        pc_and_4_d_d = pc_and_4_f;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d_q    <= NOP_INSTR;
      pc_and_4_d_q <= PC_INIT + 32'd4;
    end else begin
      instr_d_q    <= instr_d_d;
      pc_and_4_d_q <= pc_and_4_d_d;
    end
  end

  assign instr_d    = instr_d_q;
  assign pc_and_4_d = pc_and_4_d_q;

  id_stage_grf u_grf (
    .clk     (clk),
    .rst     (reset),
    .we      (we_w),
    .waddr   (waddr_w),
    .wdata   (wdata_w),
    .pc      (pc_w),
    .raddr_a (instr_d_q[RS_HI:RS_LO]),
    .raddr_b (instr_d_q[RT_HI:RT_LO]),
    .rdata_a (rs_data),
    .rdata_b (rt_data)
  );

  assign imm_ext = extend_imm(instr_d_q[IMM_HI:IMM_LO], ext_op_e'(ext_op));
  assign ifzero  = (rs_data == rt_data);
  assign ra_addr = rs_data;

endmodule
